// File: rtl/inv_key_if.sv
// inv_key_if: key-in / round-key-out stream bundle for inv_key_expand
interface inv_key_if #(
    parameter int RW = 4
);
    logic [0:3][0:3][7:0] key_in;
    logic                 key_valid;
    logic                 key_ready;
    logic [0:3][0:3][7:0] rk_out;
    logic [RW-1:0]        rk_round;
    logic                 rk_last;
    logic                 rk_valid;
    logic                 rk_ready;
    modport master (
        output key_in, key_valid, rk_ready,
        input  key_ready, rk_out, rk_round, rk_last, rk_valid
    );
    modport slave (
        input  key_in, key_valid, rk_ready,
        output key_ready, rk_out, rk_round, rk_last, rk_valid
    );
endinterface

// File: rtl/inv_key_expand.sv
// inv_key_expand: AES-128 inverse key schedule, round NR key in, round keys NR..0 out; INV_KEY_SBOX_PIPE_EN registers the S-box word (2 cycles/key)
module inv_key_expand #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input logic       clk,
    input logic       rst,
    inv_key_if.slave  bus
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // ~x picks the byte counted from the MSB end of the table
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction
    // Rcon[r] built by repeated doubling in GF(2^8), r in 1..10
    function automatic logic [7:0] rcon(input logic [RW-1:0] r);
        logic [7:0] c;
        c = 8'h01;
        for (int i = 2; i <= 10; i++)
            if (i <= int'(r)) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00);
        return c;
    endfunction
`ifdef INV_KEY_SBOX_PIPE_EN
    typedef enum logic [1:0] {IDLE, EMIT, SUB} state_t;
    localparam state_t STEP_ST = SUB;
    logic [31:0] sub_q;
`else
    typedef enum logic [1:0] {IDLE, EMIT} state_t;
    localparam state_t STEP_ST = EMIT;
`endif
    state_t state_q, state_d;
    logic [0:3][31:0] w_q, kin, prev;
    logic [RW-1:0]    rnd_q;
    logic [31:0]      w1n, w2n, w3n, sub;
    logic             accept, xfer;
    assign accept = state_q == IDLE && bus.key_valid;
    assign xfer   = state_q == EMIT && bus.rk_ready;
    // byte [j][i] of the port arrays is byte j (MSB first) of word i
    always_comb begin
        kin = '0;
        bus.rk_out = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                kin[i][31-8*j -: 8] = bus.key_in[j][i];
                bus.rk_out[j][i] = w_q[i][31-8*j -: 8];
            end
    end
    // one backward key-schedule step from round rnd_q to rnd_q-1
    always_comb begin
        w3n = w_q[3] ^ w_q[2];
        w2n = w_q[2] ^ w_q[1];
        w1n = w_q[1] ^ w_q[0];
        sub = {sbox(w3n[23:16]), sbox(w3n[15:8]), sbox(w3n[7:0]), sbox(w3n[31:24])};
`ifdef INV_KEY_SBOX_PIPE_EN
        prev = {w_q[0] ^ sub_q ^ {rcon(rnd_q), 24'h0}, w1n, w2n, w3n};
`else
        prev = {w_q[0] ^ sub ^ {rcon(rnd_q), 24'h0}, w1n, w2n, w3n};
`endif
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // next state: a round>0 transfer steps (via SUB when pipelined), round 0 transfer ends the run
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.key_valid ? EMIT : IDLE;
            EMIT:    state_d = !bus.rk_ready ? EMIT : (rnd_q == '0) ? IDLE : STEP_ST;
`ifdef INV_KEY_SBOX_PIPE_EN
            SUB:     state_d = EMIT;
`endif
            default: state_d = IDLE;
        endcase
    end
    // outputs decoded from registered state only
    always_comb begin
        bus.key_ready = state_q == IDLE;
        bus.rk_valid  = state_q == EMIT;
        bus.rk_last   = state_q == EMIT && rnd_q == '0;
        bus.rk_round  = rnd_q;
    end
    // key and round registers: load on accept, step back on each consumed round>0 key
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q   <= '0;
            rnd_q <= '0;
`ifdef INV_KEY_SBOX_PIPE_EN
            sub_q <= '0;
`endif
        end else if (accept) begin
            w_q   <= kin;
            rnd_q <= RW'(NR);
`ifdef INV_KEY_SBOX_PIPE_EN
        end else if (xfer && rnd_q != '0) begin
            sub_q <= sub;
        end else if (state_q == SUB) begin
            w_q   <= prev;
            rnd_q <= rnd_q - 1'b1;
`else
        end else if (xfer && rnd_q != '0) begin
            w_q   <= prev;
            rnd_q <= rnd_q - 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_inv_key_expand.sv
// tb_inv_key_expand: scoreboard bench for inv_key_expand, expected keys from a forward key expansion
module tb_inv_key_expand;
`ifdef INV_KEY_SBOX_PIPE_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    logic clk = 0, rst = 1;
    int   n_vec = 0, n_bad = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
    logic [7:0]   sb [256];
    logic [127:0] rk [0:10];
    logic [127:0] obs [0:15];
    logic [131:0] sb_q [$];
    logic [0:3][0:3][7:0] ob0;
    logic [132:0] snap, hold_snap;
    logic hold_pend = 0, idle_pend = 0;
    logic [131:0] e;

    inv_key_if #(.RW(4)) bus ();
    inv_key_if #(.RW(4)) bus1 ();
    inv_key_expand #(.NR(10), .RW(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    inv_key_expand #(.NR(1), .RW(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] flat(input logic [0:3][0:3][7:0] k);
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) f[127-32*i-8*j -: 8] = k[j][i];
        return f;
    endfunction

    function automatic logic [0:3][0:3][7:0] unflat(input logic [127:0] f);
        logic [0:3][0:3][7:0] k;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) k[j][i] = f[127-32*i-8*j -: 8];
        return k;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    // S-box from GF(2^8) inverse plus the affine map
    task automatic build_sbox();
        logic [7:0] inv, r, s;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r = inv;
            s = inv;
            repeat (4) begin
                r = {r[6:0], r[7]};
                s ^= r;
            end
            sb[x] = s ^ 8'h63;
        end
    endtask

    // forward AES-128 expansion of cipher key ck into rk[0..10]
    task automatic expand(input logic [127:0] ck);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 0;
            idle_pend = 0;
        end else begin
            snap = {bus.rk_valid, bus.rk_last, bus.rk_round, flat(bus.rk_out)};
            if (hold_pend) chk("hold", snap, hold_snap);
            hold_pend = bus.rk_valid && !bus.rk_ready;
            hold_snap = snap;
            if (idle_pend) begin
                chk("idle_valid", bus.rk_valid, 0);
                chk("idle_key_ready", bus.key_ready, 1);
                idle_pend = 0;
            end
            if (bus.rk_valid && bus.rk_ready) begin
                if (sb_q.size() == 0) chk("extra_key", snap, 0);
                else begin
                    e = sb_q.pop_front();
                    chk("rk", {bus.rk_last, bus.rk_round, flat(bus.rk_out)}, {e[131:128] == 4'd0, e});
                    obs[bus.rk_round] = flat(bus.rk_out);
                    if (bus.rk_round == 4'd10) first_cyc = cyc;
                    if (bus.rk_round == 4'd0) begin
                        last_cyc = cyc;
                        ob0 = bus.rk_out;
                        idle_pend = 1;
                    end
                end
            end
        end
    end

    // mode 0: ready high, 1: random ready, 2: key_valid pulsed mid-run, 3: reset at round 5
    task automatic run(input logic [127:0] ck, input int mode);
        expand(ck);
        for (int r = 10; r >= 0; r--) sb_q.push_back({4'(r), rk[r]});
        bus.key_in = unflat(rk[10]);
        bus.key_valid = 1;
        bus.rk_ready = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #1;
        bus.key_valid = 0;
        for (int c = 0; c < 300 && sb_q.size() > 0; c++) begin
            bus.key_in = unflat({$urandom, $urandom, $urandom, $urandom});
            bus.key_valid = mode == 2 && c == 2;
            if (mode == 3 && bus.rk_valid && bus.rk_round == 4'd5) begin
                rst = 1;
                #1;
                chk("rst_valid", bus.rk_valid, 0);
                chk("rst_round", bus.rk_round, 0);
                sb_q.delete();
                @(posedge clk);
                #1;
                rst = 0;
                chk("rst_key_ready", bus.key_ready, 1);
                break;
            end
            bus.rk_ready = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
        end
        bus.key_valid = 0;
        chk("pending", sb_q.size(), 0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after", {bus.rk_valid, bus.key_ready}, 2'b01);
        if (mode == 0) chk("latency", last_cyc - first_cyc, STEP * 10);
    endtask

    initial begin
        build_sbox();
        bus.key_in = '0; bus.key_valid = 0; bus.rk_ready = 0;
        bus1.key_in = '0; bus1.key_valid = 0; bus1.rk_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {bus.rk_valid, bus.rk_last, bus.rk_round, flat(bus.rk_out)}, 0);
        rst = 0;
        #1;
        chk("reset_key_ready", bus.key_ready, 1);
        @(posedge clk);
        #1;
        run(128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
        chk("fips_rd10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_rd9", obs[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("fips_rd1", obs[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_rd0", obs[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("byte_00", ob0[0][0], 8'h2b);
        chk("byte_10", ob0[1][0], 8'h7e);
        chk("byte_33", ob0[3][3], 8'h3c);
        run(128'h2b7e151628aed2a6abf7158809cf4f3c, 1);
        run({$urandom, $urandom, $urandom, $urandom}, 1);
        run({$urandom, $urandom, $urandom, $urandom}, 0);
        run({$urandom, $urandom, $urandom, $urandom}, 2);
        run(128'h2b7e151628aed2a6abf7158809cf4f3c, 3);
        run(128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
        bus1.key_in = unflat(128'ha0fafe1788542cb123a339392a6c7605);
        bus1.key_valid = 1;
        bus1.rk_ready = 1;
        @(posedge clk);
        #1;
        bus1.key_valid = 0;
        chk("nr1_first", {bus1.rk_valid, bus1.rk_last, bus1.rk_round, flat(bus1.rk_out)},
            {1'b1, 1'b0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605});
        for (int c = 0; c < 20 && !(bus1.rk_valid && bus1.rk_last); c++) begin
            @(posedge clk);
            #1;
        end
        chk("nr1_last", {bus1.rk_valid, bus1.rk_last, bus1.rk_round, flat(bus1.rk_out)},
            {1'b1, 1'b1, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c});
        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/inv_key_expand.md
Name: inv_key_expand

Overview:
- Sequential AES-128 inverse key schedule for the decryption datapath.
- Takes the last round key and walks the key schedule backwards, emitting round keys NR, NR-1, … 0 one at a time on a valid/ready stream. Round 0 is the cipher key.
- It is the reverse direction of the forward word-XOR key step: it feeds the inverse cipher rounds without storing the full expanded schedule.

Parameters:
- NR, 10, number of rounds to unwind. Legal range 1..10; round indices run NR down to 0.
- RW, 4, width of the round-index output.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- key_in  input  8 x [0:3][0:3]  round-NR key. Byte [j][i] is byte j of word i; byte [0][i] is the MSB of the word.
- key_valid  input  1  key_in valid.
- key_ready  output  1  block can accept a key (IDLE only).
- rk_out  output  8 x [0:3][0:3]  current round key, same byte layout as key_in.
- rk_round  output  RW  round index of rk_out.
- rk_last  output  1  high when rk_round == 0.
- rk_valid  output  1  rk_out/rk_round/rk_last valid.
- rk_ready  input  1  consumer accepts the current key.

Behaviour:
- Reset (async, immediate, including mid-run):
  - state=IDLE; key register, rk_round, rk_last and rk_valid all 0.
  - key_ready=1 once rst deasserts.
  - Any run in progress is abandoned with no further output.
- State machine (base build): IDLE, EMIT.
  - IDLE: key_ready=1, rk_valid=0. On key_valid&&key_ready, next cycle: key reg=key_in, rk_round=NR, state=EMIT.
  - EMIT: key_ready=0, rk_valid=1. Outputs are driven straight from registers; there is no combinational path from the inputs to the outputs.
  - rk_valid&&!rk_ready: all outputs held stable.
  - rk_valid&&rk_ready&&rk_round>0: key reg=previous key, rk_round-=1, stay in EMIT. Back-to-back, one key per cycle.
  - rk_valid&&rk_ready&&rk_round==0: state=IDLE, rk_valid=0. key_ready rises in the same cycle; no new key is taken during that transfer cycle.
- Latency: key accepted at cycle t → rk_round=NR valid at t+1. With rk_ready tied high, round 0 is valid at t+1+NR.
- Inverse step from round r key w0..w3 to round r-1 key w0'..w3' (32-bit XORs):
  - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0.
  - w0'=w0^SubWord(RotWord(w3'))^{Rcon[r],00,00,00}.
  - RotWord: [b0,b1,b2,b3]→[b1,b2,b3,b0].
  - SubWord: forward AES S-box on each byte (4 combinational instances).
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, indexed by the current rk_round (before decrement).
- rk_last = (rk_round==0) whenever rk_valid; 0 otherwise.
- key_valid while not IDLE is ignored; there is no queueing.
- key_in changing while key_ready=0 has no effect.

Optional Feature:
- Macro INV_KEY_SBOX_PIPE_EN.
- Defined:
  - Adds state SUB and a 32-bit register holding SubWord(RotWord(w3')) for the next step.
  - On a round>0 transfer in EMIT, go to SUB for exactly one cycle with rk_valid=0. The key reg updates on leaving SUB, then return to EMIT.
  - Effect: 2 cycles per key, round 0 at t+1+2*NR with rk_ready high, shorter critical path.
  - Reset clears the extra register; reset during SUB → IDLE.
- Undefined: single-cycle step exactly as in Behaviour; state SUB does not exist.

Test Plan:
- FIPS-197 unwind:
  - Stimulus: key_in = d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1.
  - Required: rd10 = d014f9a8c9ee2589e13f0cc8b6630ca6, rd9 = ac7766f319fadc2128d12941575c006e, rd1 = a0fafe1788542cb123a339392a6c7605.
  - Required: rd0 = 2b7e151628aed2a6abf7158809cf4f3c with rk_last=1, then rk_valid=0 and key_ready=1 the following cycle.
- Byte order: in the same run, rk_out[0][0]=2b, rk_out[1][0]=7e, rk_out[3][3]=3c at round 0.
- Backpressure:
  - Stimulus: random rk_ready (~50%).
  - Required: outputs held stable while stalled, and the same 11 keys in order with no skipped or repeated round indices.
- Busy / reset:
  - Stimulus: key_valid pulsed during EMIT.
  - Required: key ignored.
  - Stimulus: rst asserted at rk_round=5.
  - Required: rk_valid=0 immediately; a fresh run after release restarts at round 10.
- Throughput:
  - Stimulus: rk_ready=1, macro undefined.
  - Required: 11 consecutive valid cycles.
  - Stimulus: macro defined.
  - Required: valid high on alternate cycles; round 0 at t+21.
- NR=1: round-1 key a0fafe1788542cb123a339392a6c7605 in → 2b7e151628aed2a6abf7158809cf4f3c out with rk_last=1.
